// File: rtl/counter_sequencer.sv
// counter_sequencer: arms an external counter block, waits for its stop flag,
// snapshots every channel count and streams the enabled channels out, repeating
// for n_runs acquisitions per sequence.
// Optional feature macro: CNTSEQ_ACCUM_EN -- accumulate snapshots per channel
// (saturating) over all runs and stream only the sums after the final run.
module counter_sequencer #(
  parameter int unsigned N_CHN       = 32,
  parameter int unsigned TIMEOUT_CYC = 32'd1_000_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run_req,
  input  logic [7:0]            n_runs,
  input  logic [N_CHN-1:0]      chan_en,
  input  logic                  abort,
  output logic                  cnt_start,
  input  logic                  cnt_stop,
  input  logic [32*N_CHN-1:0]   cnt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [4:0]            out_chan,
  output logic [7:0]            out_run,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = (N_CHN > 1) ? $clog2(N_CHN) : 1;

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_STOP, STREAM, WAIT_LOW, DONE
  } state_t;

  state_t           state;
  logic [7:0]       n_lat;
  logic [N_CHN-1:0] en_lat;
  logic [7:0]       run_idx;
  logic [31:0]      wdog;
  logic [N_CHN-1:0] pending;
  logic [DW-1:0]    snap [N_CHN];

  logic [CW-1:0]    sel;
  logic [N_CHN-1:0] rest;
  logic             last_run;
  logic             wdog_exp;

`ifdef CNTSEQ_ACCUM_EN
  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? '1 : s[DW-1:0];
  endfunction
`endif

  // Lowest pending channel, the mask left after it, and run/watchdog limits.
  always_comb begin
    sel = '0;
    for (int k = N_CHN - 1; k >= 0; k--) begin
      if (pending[k]) sel = CW'(k);
    end
    rest      = pending;
    rest[sel] = 1'b0;
    last_run  = ({1'b0, run_idx} + 9'd1) >= {1'b0, n_lat};
    wdog_exp  = (33'(wdog) + 33'd1) >= 33'(TIMEOUT_CYC);
  end

  // Sequencer FSM with registered outputs; abort overrides every transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      n_lat       <= '0;
      en_lat      <= '0;
      run_idx     <= '0;
      wdog        <= '0;
      pending     <= '0;
      cnt_start   <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_chan    <= '0;
      out_run     <= '0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      for (int k = 0; k < N_CHN; k++) snap[k] <= '0;
    end else begin
      cnt_start <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (run_req) begin
              state       <= ARM;
              cnt_start   <= 1'b1;
              busy        <= 1'b1;
              err_timeout <= 1'b0;
              run_idx     <= '0;
              n_lat       <= (n_runs == 8'd0) ? 8'd1 : n_runs;
              en_lat      <= chan_en;
`ifdef CNTSEQ_ACCUM_EN
              for (int k = 0; k < N_CHN; k++) snap[k] <= '0;
`endif
            end
          end
          ARM: begin
            wdog  <= '0;
            state <= WAIT_STOP;
          end
          WAIT_STOP: begin
            if (cnt_stop) begin
`ifdef CNTSEQ_ACCUM_EN
              for (int k = 0; k < N_CHN; k++)
                snap[k] <= sat_add(snap[k], cnt_data[DW*k +: DW]);
              if (last_run) begin
                pending <= en_lat;
                state   <= STREAM;
              end else begin
                state <= WAIT_LOW;
              end
`else
              for (int k = 0; k < N_CHN; k++) snap[k] <= cnt_data[DW*k +: DW];
              pending <= en_lat;
              state   <= STREAM;
`endif
            end else if (wdog_exp) begin
              err_timeout <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else if (wdog != '1) begin
              wdog <= wdog + 32'd1;
            end
          end
          STREAM: begin
            if (!out_valid || out_ready) begin
              if (|pending) begin
                out_valid <= 1'b1;
                out_data  <= snap[sel];
                out_chan  <= 5'(sel);
                out_run   <= run_idx;
                out_last  <= ~|rest;
                pending   <= rest;
              end else begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                state     <= WAIT_LOW;
              end
            end
          end
          WAIT_LOW: begin
            if (!cnt_stop) begin
              if (!last_run) begin
                run_idx   <= run_idx + 8'd1;
                cnt_start <= 1'b1;
                state     <= ARM;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed bench with a small counter-block model.
`timescale 1ns/1ps
module tb_counter_sequencer;

  localparam int unsigned N = 32;

  logic            clk = 1'b0;
  logic            reset_n, run_req, abort, cnt_stop, out_ready;
  logic [7:0]      n_runs;
  logic [N-1:0]    chan_en;
  logic [32*N-1:0] cnt_data;
  logic            cnt_start, out_valid, out_last, busy, done, err_timeout;
  logic [31:0]     out_data;
  logic [4:0]      out_chan;
  logic [7:0]      out_run;
  logic            run_req_t, abort_t;
  logic            cnt_start_t, out_valid_t, out_last_t, busy_t, done_t, err_timeout_t;
  logic [31:0]     out_data_t;
  logic [4:0]      out_chan_t;
  logic [7:0]      out_run_t;

  always #5 clk = ~clk;

  counter_sequencer #(.N_CHN(N), .TIMEOUT_CYC(1000)) dut (
    .clk(clk), .reset_n(reset_n), .run_req(run_req), .n_runs(n_runs),
    .chan_en(chan_en), .abort(abort), .cnt_start(cnt_start), .cnt_stop(cnt_stop),
    .cnt_data(cnt_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_chan(out_chan), .out_run(out_run),
    .out_last(out_last), .busy(busy), .done(done), .err_timeout(err_timeout));

  counter_sequencer #(.N_CHN(N), .TIMEOUT_CYC(50)) dut_t (
    .clk(clk), .reset_n(reset_n), .run_req(run_req_t), .n_runs(n_runs),
    .chan_en(chan_en), .abort(abort_t), .cnt_start(cnt_start_t), .cnt_stop(cnt_stop),
    .cnt_data(cnt_data), .out_valid(out_valid_t), .out_ready(out_ready),
    .out_data(out_data_t), .out_chan(out_chan_t), .out_run(out_run_t),
    .out_last(out_last_t), .busy(busy_t), .done(done_t), .err_timeout(err_timeout_t));

  typedef struct {
    logic [7:0]  r;
    logic [4:0]  ch;
    logic        l;
    logic [31:0] d;
  } beat_t;

  int          n_checks, n_fail;
  beat_t       beats[$];
  int          starts, dones, stall_err, stop_bad;
  logic        prev_stall, prev_abort;
  logic [31:0] pd;
  logic [4:0]  pc;
  logic [7:0]  pr;
  bit          pend, toggle_rdy;
  int          dly, hold, mrun, d_cfg, h_cfg;
  logic [31:0] pat [4][N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int row);
    int rr;
    rr = (row < 0) ? 0 : ((row > 3) ? 3 : row);
    for (int c = 0; c < N; c++) cnt_data[32*c +: 32] = pat[rr][c];
  endtask

  // One clock: sample at the falling edge, then drive just after the rising edge.
  task automatic tick();
    beat_t b;
    @(negedge clk);
    if (out_valid && out_ready) begin
      b.r = out_run; b.ch = out_chan; b.l = out_last; b.d = out_data;
      beats.push_back(b);
    end
    if (prev_stall && !prev_abort)
      if (!out_valid || out_data != pd || out_chan != pc || out_run != pr) stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_abort = abort;
    pd = out_data; pc = out_chan; pr = out_run;
    if (cnt_start) begin starts++; pend = 1; dly = 0; mrun++; end
    if (done) begin dones++; if (cnt_stop) stop_bad++; end
    @(posedge clk); #1;
    if (toggle_rdy) out_ready = ~out_ready;
    if (pend) begin
      dly++;
      if (dly >= d_cfg) begin pend = 0; cnt_stop = 1'b1; hold = 0; load(mrun - 1); end
    end else if (cnt_stop) begin
      hold++;
      if (hold >= h_cfg) cnt_stop = 1'b0;
    end
  endtask

  task automatic start_seq(input logic [7:0] nr, input logic [N-1:0] en);
    beats.delete();
    starts = 0; dones = 0; stall_err = 0; stop_bad = 0; mrun = 0;
    n_runs = nr; chan_en = en; run_req = 1'b1;
    tick();
    run_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int i;
    i = 0;
    while (dones == 0 && i < budget) begin tick(); i++; end
    check({tag, "_done_in_time"}, 64'(i < budget), 64'd1);
    tick(); tick();
  endtask

  task automatic clear_pat();
    for (int r = 0; r < 4; r++) for (int c = 0; c < N; c++) pat[r][c] = '0;
  endtask

  initial begin
    int first_done, i;
    logic err51, err52, any_valid;
    n_checks = 0; n_fail = 0;
    reset_n = 1'b0; run_req = 1'b0; abort = 1'b0; cnt_stop = 1'b0; out_ready = 1'b1;
    n_runs = '0; chan_en = '0; cnt_data = '0; run_req_t = 1'b0; abort_t = 1'b0;
    pend = 0; toggle_rdy = 0; dly = 0; hold = 0; mrun = 0; d_cfg = 3; h_cfg = 2;
    prev_stall = 0; prev_abort = 0; pd = '0; pc = '0; pr = '0;
    starts = 0; dones = 0; stall_err = 0; stop_bad = 0;
    clear_pat();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({cnt_start, out_valid, out_last, busy, done, err_timeout}), 64'd0);
    check("reset_data", 64'({out_data, out_chan, out_run}), 64'd0);
    check("reset_ctrl_t", 64'({cnt_start_t, out_valid_t, busy_t, done_t, err_timeout_t}), 64'd0);
    reset_n = 1'b1;
    tick();

    // Two sparse channels, stop after ~100 cycles, held well into the stream.
    pat[0][0] = 32'd10; pat[0][2] = 32'd7;
    d_cfg = 100; h_cfg = 20;
    start_seq(8'd1, 32'h0000_0005);
    check("t21_busy", 64'(busy), 64'd1);
    repeat (5) tick();
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_done(400, "t21");
    check("t21_nbeats", 64'(beats.size()), 64'd2);
    if (beats.size() >= 2) begin
      check("t21_beat0", 64'({beats[0].r, beats[0].ch, beats[0].l, beats[0].d}),
            64'({8'd0, 5'd0, 1'b0, 32'd10}));
      check("t21_beat1", 64'({beats[1].r, beats[1].ch, beats[1].l, beats[1].d}),
            64'({8'd0, 5'd2, 1'b1, 32'd7}));
    end
    check("t21_starts", 64'(starts), 64'd1);
    check("t21_done_after_stop_low", 64'(stop_bad), 64'd0);
    check("t21_idle", 64'({busy, err_timeout}), 64'd0);

    // Three runs, all channels, ready toggling each cycle.
    clear_pat();
    for (int r = 0; r < 3; r++) for (int c = 0; c < N; c++) pat[r][c] = 32'((r + 1) * 256 + c);
    d_cfg = 5; h_cfg = 2; toggle_rdy = 1;
    start_seq(8'd3, '1);
    wait_done(2000, "t22");
    toggle_rdy = 0; out_ready = 1'b1;
`ifdef CNTSEQ_ACCUM_EN
    check("t22_nbeats", 64'(beats.size()), 64'd32);
    for (int k = 0; k < 32 && k < beats.size(); k++)
      check("t22_beat", 64'({beats[k].r, beats[k].ch, beats[k].l, beats[k].d}),
            64'({8'd2, 5'(k), k == 31, 32'(32'h600 + 3 * k)}));
`else
    check("t22_nbeats", 64'(beats.size()), 64'd96);
    for (int k = 0; k < 96 && k < beats.size(); k++)
      check("t22_beat", 64'({beats[k].r, beats[k].ch, beats[k].l, beats[k].d}),
            64'({8'(k / 32), 5'(k % 32), (k % 32) == 31, 32'((k / 32 + 1) * 256 + k % 32)}));
`endif
    check("t22_starts", 64'(starts), 64'd3);
    check("t22_stall_stable", 64'(stall_err), 64'd0);

    // No channels enabled, two runs.
    clear_pat();
    start_seq(8'd2, '0);
    wait_done(300, "t26");
    check("t26_nbeats", 64'(beats.size()), 64'd0);
    check("t26_starts", 64'(starts), 64'd2);
    check("t26_dones", 64'(dones), 64'd1);

    // n_runs=0 behaves as one run; edge channels 0 and 31.
    pat[0][0] = 32'hAA; pat[0][31] = 32'hBB;
    start_seq(8'd0, 32'h8000_0001);
    wait_done(300, "nr0");
    check("nr0_starts", 64'(starts), 64'd1);
    check("nr0_nbeats", 64'(beats.size()), 64'd2);
    if (beats.size() >= 2)
      check("nr0_beat1", 64'({beats[1].r, beats[1].ch, beats[1].l, beats[1].d}),
            64'({8'd0, 5'd31, 1'b1, 32'hBB}));

`ifdef CNTSEQ_ACCUM_EN
    // Saturating accumulation over two runs.
    clear_pat();
    pat[0][1] = 32'hFFFF_FFF0; pat[1][1] = 32'h20;
    start_seq(8'd2, 32'h0000_0002);
    wait_done(300, "t25");
    check("t25_nbeats", 64'(beats.size()), 64'd1);
    if (beats.size() >= 1)
      check("t25_beat", 64'({beats[0].r, beats[0].ch, beats[0].l, beats[0].d}),
            64'({8'd1, 5'd1, 1'b1, 32'hFFFF_FFFF}));
`endif

    // Abort while the fifth beat is on the bus.
    clear_pat();
    for (int c = 0; c < N; c++) pat[0][c] = 32'(c + 1);
    for (int c = 0; c < N; c++) pat[1][c] = 32'(c + 1);
    start_seq(8'd2, '1);
    i = 0;
    while (beats.size() < 4 && i < 300) begin tick(); i++; end
    check("t24_reach_beat5", 64'(i < 300), 64'd1);
    check("t24_beat5_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0; abort = 1'b1;
    tick();
    check("t24_after_abort", 64'({out_valid, done, busy}), 64'b010);
    abort = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    check("t24_nbeats", 64'(beats.size()), 64'd4);
    check("t24_dones", 64'(dones), 64'd1);
    pat[0][0] = 32'd10; pat[0][2] = 32'd7;
    start_seq(8'd1, 32'h0000_0005);
    wait_done(300, "t24_restart");
    check("t24_restart_nbeats", 64'(beats.size()), 64'd2);
    if (beats.size() >= 1)
      check("t24_restart_beat0", 64'({beats[0].r, beats[0].ch, beats[0].d}),
            64'({8'd0, 5'd0, 32'd10}));
    check("t24_restart_err", 64'(err_timeout), 64'd0);

    // Reset mid-sequence ends it with no done pulse.
    d_cfg = 10000;
    start_seq(8'd1, 32'h1);
    repeat (10) tick();
    reset_n = 1'b0; pend = 0;
    #1;
    check("t19_reset_outs", 64'({busy, done, cnt_start}), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) tick();
    check("t19_no_done", 64'(dones), 64'd0);
    check("t19_idle", 64'(busy), 64'd0);
    d_cfg = 3;

    // Watchdog expiry on the 50-cycle instance.
    cnt_stop = 1'b0;
    run_req_t = 1'b1;
    @(posedge clk); #1;
    run_req_t = 1'b0;
    first_done = 0; err51 = 1'b1; err52 = 1'b0; any_valid = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 1) check("t23_cnt_start", 64'(cnt_start_t), 64'd1);
      if (done_t && first_done == 0) first_done = j;
      if (out_valid_t) any_valid = 1'b1;
      if (j == 51) err51 = err_timeout_t;
      if (j == 52) err52 = err_timeout_t;
    end
    check("t23_done_cycle", 64'(first_done), 64'd52);
    check("t23_err_edge", 64'({err51, err52}), 64'b01);
    check("t23_no_beats", 64'(any_valid), 64'd0);
    check("t23_idle", 64'({busy_t, err_timeout_t}), 64'b01);
    @(posedge clk); #1;
    run_req_t = 1'b1;
    @(posedge clk); #1;
    run_req_t = 1'b0;
    check("t23_err_cleared", 64'({err_timeout_t, busy_t, cnt_start_t}), 64'b011);
    abort_t = 1'b1;
    @(posedge clk); #1;
    abort_t = 1'b0;
    check("t23_abort", 64'({done_t, busy_t, err_timeout_t}), 64'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 The module SHALL have parameter N_CHN, default 32, giving the number of counter channels (1..32).
REQ-002 The module SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000_000, giving the maximum number of clk cycles to wait for cnt_stop after cnt_start.
REQ-003 The module SHALL have the following ports, one per line (name direction width meaning):
 clk  in  1  single clock; all state changes on its rising edge
 reset_n  in  1  asynchronous, active-low reset
 run_req  in  1  request an acquisition sequence; sampled in IDLE only
 n_runs  in  8  number of acquisitions per sequence, latched at run_req; 0 treated as 1
 chan_en  in  N_CHN  per-channel stream enable, latched at run_req
 abort  in  1  terminate the sequence
 cnt_start  out  1  one-cycle start pulse to the counter block
 cnt_stop  in  1  stop/ready flag from the counter block
 cnt_data  in  32*N_CHN  channel counts; channel k at bits [32k+31:32k]
 out_valid / out_ready  out / in  1 / 1  stream handshake
 out_data  out  32  channel count
 out_chan  out  5  channel index
 out_run  out  8  run index, 0-based
 out_last  out  1  last beat of a batch
 busy  out  1  high in every state except IDLE
 done  out  1  one-cycle pulse at sequence end
 err_timeout  out  1  sticky timeout flag, cleared by the next accepted run_req

Function
REQ-004 The FSM SHALL have states IDLE, ARM, WAIT_STOP, STREAM, WAIT_LOW, DONE.
REQ-005 IDLE -> ARM when run_req=1; n_runs and chan_en latched; run index cleared; err_timeout cleared.
REQ-006 ARM SHALL assert cnt_start for exactly one cycle, clear the watchdog, then go to WAIT_STOP.
REQ-007 In WAIT_STOP the first cycle with cnt_stop=1 SHALL snapshot all cnt_data into internal registers, then go to STREAM.
REQ-008 If the watchdog reaches TIMEOUT_CYC in WAIT_STOP, the FSM SHALL set err_timeout, emit no beats, pulse done and return to IDLE.
REQ-009 STREAM SHALL present channels in ascending index order and skip channels with chan_en[k]=0; out_data/out_chan/out_run SHALL remain stable while out_valid=1 and out_ready=0.
REQ-010 A beat transfers when out_valid and out_ready are both high; the next enabled channel SHALL be presented in the following cycle, giving one beat per cycle at full throughput.
REQ-011 out_last SHALL be 1 only on the highest-index enabled channel of a batch.
REQ-012 If chan_en is all zero, STREAM SHALL produce no beats and exit in one cycle.
REQ-013 After the batch, the FSM SHALL go to WAIT_LOW and stay there until cnt_stop=0; it then goes to ARM if run index+1 < effective n_runs (run index incremented), else to DONE.
REQ-014 DONE SHALL pulse done for one cycle and go to IDLE.
REQ-015 abort=1 in any non-IDLE state SHALL drop out_valid, pulse done and go to IDLE in the next cycle; abort SHALL take priority over every other transition.
REQ-016 run_req while busy=1 SHALL be ignored.
REQ-017 The watchdog SHALL be 32 bits and SHALL NOT wrap.

Reset
REQ-018 With reset_n=0 the FSM SHALL be in IDLE; cnt_start, out_valid, out_last, busy, done and err_timeout SHALL be 0; out_data, out_chan and out_run SHALL be 0; snapshot registers SHALL be cleared.
REQ-019 Reset asserted mid-sequence SHALL end the sequence immediately without a done pulse.

Configuration
REQ-020 With macro CNTSEQ_ACCUM_EN defined, each run SHALL add its snapshot to a per-channel 32-bit accumulator that saturates at 32'hFFFF_FFFF. STREAM SHALL run only after the final run and output the sums with out_run = n_runs-1. Without the macro, every run SHALL stream its own snapshot and no accumulators SHALL exist.

Verification
REQ-021 n_runs=1, chan_en=32'h0000_0005, cnt_stop raised 100 cycles after cnt_start with ch0=10, ch2=7, out_ready=1 -> beats (0,10,last=0) then (2,7,last=1), then done after cnt_stop falls.
REQ-022 n_runs=3, all channels enabled, out_ready toggling 1/0 -> 96 beats; out_run=0,1,2; data stable while stalled; exactly three cnt_start pulses.
REQ-023 TIMEOUT_CYC=50, cnt_stop never raised -> err_timeout=1 and done on cycle 51 of WAIT_STOP; no beats.
REQ-024 abort asserted during beat 5 of STREAM -> out_valid=0 in the next cycle; done pulse; IDLE; the next run_req clears nothing erroneously and restarts at run 0.
REQ-025 With CNTSEQ_ACCUM_EN, n_runs=2, ch1=32'hFFFF_FFF0 then 32'h20 -> single beat ch1=32'hFFFF_FFFF, out_run=1.
REQ-026 chan_en=0, n_runs=2 -> no beats, two cnt_start pulses, done asserted.
